// File: rtl/pref_pkg.sv
// Shared prefetch types: address/line widths and line-address helpers.
// Also imported by the IP-stride prefetcher.
package pref_pkg;

  localparam int ADDR_SIZE       = 64;
  localparam int LOG2_BLOCK_SIZE = 6;
  localparam int CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CLA_SIZE-1:0]  cla_t;

  function automatic cla_t to_cla(input addr_t addr);
    return addr[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  endfunction

  function automatic addr_t from_cla(input cla_t cla);
    return {cla, {LOG2_BLOCK_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/pref_cla_match.sv
// N-entry valid/line-address CAM: hit_o is set when any valid entry equals key_i.
// Entries arrive flattened, entry i at cla_i[i*W +: W].
module pref_cla_match
  import pref_pkg::*;
#(
  parameter int N = 8,
  parameter int W = CLA_SIZE
) (
  input  logic [N-1:0]   valid_i,
  input  logic [N*W-1:0] cla_i,
  input  logic [W-1:0]   key_i,
  output logic           hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i] && (cla_i[i*W +: W] == key_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/pref_queue.sv
// Prefetch request queue: dedups up to three candidates per cycle, buffers them in a
// circular FIFO and issues one per cycle. Address widths come from pref_pkg.
// Optional recent-issue filter: define PREF_QUEUE_RECENT_FILTER_EN.
module pref_queue
  import pref_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int FILTER_ENTRIES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_SIZE-1:0]   pref_addr1_i,
  input  logic [ADDR_SIZE-1:0]   pref_addr2_i,
  input  logic [ADDR_SIZE-1:0]   pref_addr3_i,
  input  logic                   pref_valid1_i,
  input  logic                   pref_valid2_i,
  input  logic                   pref_valid3_i,
  input  logic                   flush_i,
  output logic [ADDR_SIZE-1:0]   req_addr_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DEPTH-1:0]       occ_q, occ_d;
  cla_t                   mem_q [DEPTH];
  cla_t                   mem_d [DEPTH];
  logic [DEPTH*CLA_SIZE-1:0] mem_flat;
  logic                   req_valid_q, req_valid_d;
  logic [ADDR_SIZE-1:0]   req_addr_q, req_addr_d;
  logic [15:0]            drop_q, drop_d;

  cla_t                   cand_cla [3];
  logic [2:0]             cand_v, fifo_hit, filt_hit, keep;
  logic [CW-1:0]          space, n_keep, n_enq, n_drop, slot;
  logic [16:0]            drop_sum;
  logic                   deq;
  logic                   unused_addr_lsbs;

  assign cand_cla[0] = to_cla(pref_addr1_i);
  assign cand_cla[1] = to_cla(pref_addr2_i);
  assign cand_cla[2] = to_cla(pref_addr3_i);
  assign cand_v      = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign unused_addr_lsbs = ^{pref_addr1_i[LOG2_BLOCK_SIZE-1:0],
                              pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                              pref_addr3_i[LOG2_BLOCK_SIZE-1:0]};

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*CLA_SIZE +: CLA_SIZE] = mem_q[g];
  end

  // Occupied entries include the head even when it is handed off this cycle.
  for (genvar g = 0; g < 3; g++) begin : g_fifo_match
    pref_cla_match #(.N(DEPTH), .W(CLA_SIZE)) u_fifo_match (
      .valid_i (occ_q),
      .cla_i   (mem_flat),
      .key_i   (cand_cla[g]),
      .hit_o   (fifo_hit[g])
    );
  end

`ifdef PREF_QUEUE_RECENT_FILTER_EN
  localparam int FW = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;

  cla_t                           filt_q [FILTER_ENTRIES];
  logic [FILTER_ENTRIES-1:0]      filt_v_q;
  logic [FW-1:0]                  filt_ptr_q;
  logic [FILTER_ENTRIES*CLA_SIZE-1:0] filt_flat;

  for (genvar g = 0; g < FILTER_ENTRIES; g++) begin : g_filt_flat
    assign filt_flat[g*CLA_SIZE +: CLA_SIZE] = filt_q[g];
  end

  for (genvar g = 0; g < 3; g++) begin : g_filt_match
    pref_cla_match #(.N(FILTER_ENTRIES), .W(CLA_SIZE)) u_filt_match (
      .valid_i (filt_v_q),
      .cla_i   (filt_flat),
      .key_i   (cand_cla[g]),
      .hit_o   (filt_hit[g])
    );
  end

  // Filter survives flush on purpose: a flushed line was still issued recently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FILTER_ENTRIES; i++) filt_q[i] <= '0;
      filt_v_q   <= '0;
      filt_ptr_q <= '0;
    end else if (deq) begin
      filt_q[filt_ptr_q]   <= mem_q[head_q];
      filt_v_q[filt_ptr_q] <= 1'b1;
      filt_ptr_q <= (filt_ptr_q == FW'(FILTER_ENTRIES - 1)) ? '0 : filt_ptr_q + FW'(1);
    end
  end
`else
  localparam int unused_filter_entries = FILTER_ENTRIES;
  assign filt_hit = '0;
`endif

  always_comb begin
    deq   = req_valid_q & req_ready_i;
    space = CW'(DEPTH) - count_q;

    keep[0] = cand_v[0] & ~fifo_hit[0] & ~filt_hit[0];
    keep[1] = cand_v[1] & ~fifo_hit[1] & ~filt_hit[1]
            & ~(cand_v[0] && (cand_cla[1] == cand_cla[0]));
    keep[2] = cand_v[2] & ~fifo_hit[2] & ~filt_hit[2]
            & ~(cand_v[0] && (cand_cla[2] == cand_cla[0]))
            & ~(cand_v[1] && (cand_cla[2] == cand_cla[1]));

    n_keep = CW'(keep[0]) + CW'(keep[1]) + CW'(keep[2]);
    n_enq  = (n_keep > space) ? space : n_keep;
    n_drop = n_keep - n_enq;

    mem_d  = mem_q;
    occ_d  = occ_q;
    head_d = head_q;
    slot   = '0;

    if (deq) begin
      occ_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end

    for (int k = 0; k < 3; k++) begin
      if (keep[k] && (slot < n_enq)) begin
        mem_d[tail_q + PW'(slot)] = cand_cla[k];
        occ_d[tail_q + PW'(slot)] = 1'b1;
        slot = slot + CW'(1);
      end
    end

    tail_d   = tail_q + PW'(n_enq);
    count_d  = count_q + n_enq - CW'(deq);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      occ_d   = '0;
      drop_d  = drop_q;
    end

    // Registered head view keeps req_* free of any input-to-output path.
    req_valid_d = (count_d != '0);
    req_addr_d  = from_cla(mem_d[head_d]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_addr_o  = req_addr_q;
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_pref_queue.sv
// Scoreboard bench for pref_queue: a queue-based line-address model predicts status
// and issue order; a negedge monitor compares whatever the DUT presents.
module tb_pref_queue;

  localparam int DEPTH = 8;
  localparam int FENT  = 16;
  typedef logic [63:0] a64;
  typedef struct { int cnt; int drop; bit vld; } st_t;

  logic       clk, rst;
  a64         a1, a2, a3;
  logic       v1, v2, v3, flush, ready;
  a64         req_addr;
  logic       req_valid;
  logic [3:0] count;
  logic [15:0] drop_cnt;

  pref_queue #(.DEPTH(DEPTH), .FILTER_ENTRIES(FENT)) dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(a1), .pref_addr2_i(a2), .pref_addr3_i(a3),
    .pref_valid1_i(v1), .pref_valid2_i(v2), .pref_valid3_i(v3),
    .flush_i(flush),
    .req_addr_o(req_addr), .req_valid_o(req_valid), .req_ready_i(ready),
    .count_o(count), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_cmp = 0, n_bad = 0;
  bit  mon_en = 0;
  a64  mq[$];
  a64  filt[$];
  int  m_drop = 0;
  st_t exp_st[$];
  a64  exp_issue[$];

  task automatic chk(input string nm, input a64 act, input a64 exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next cycle, drive one set of inputs and step the model.
  task automatic cyc(input bit b1, input a64 x1, input bit b2, input a64 x2,
                     input bit b3, input a64 x3, input bit fl, input bit rdy);
    bit bv[3];
    a64 ba[3];
    a64 c[3];
    bit kp[3];
    bit deq;
    int space;
    st_t s;
    @(posedge clk); #1;
    v1 = b1; a1 = x1; v2 = b2; a2 = x2; v3 = b3; a3 = x3; flush = fl; ready = rdy;
    s.cnt = mq.size(); s.drop = m_drop; s.vld = (mq.size() > 0);
    exp_st.push_back(s);
    mon_en = 1;
    bv[0] = b1; bv[1] = b2; bv[2] = b3;
    ba[0] = x1; ba[1] = x2; ba[2] = x3;
    space = DEPTH - mq.size();
    deq = (mq.size() > 0) && rdy;
    for (int k = 0; k < 3; k++) begin
      c[k]  = ba[k] >> 6;
      kp[k] = bv[k];
      for (int j = 0; j < k; j++) if (bv[j] && c[j] == c[k]) kp[k] = 0;
      foreach (mq[i]) if (mq[i] == c[k]) kp[k] = 0;
`ifdef PREF_QUEUE_RECENT_FILTER_EN
      foreach (filt[i]) if (filt[i] == c[k]) kp[k] = 0;
`endif
    end
    if (deq) begin
      exp_issue.push_back(mq[0] << 6);
      filt.push_back(mq[0]);
      if (filt.size() > FENT) void'(filt.pop_front());
      void'(mq.pop_front());
    end
    if (fl) mq.delete();
    else begin
      for (int k = 0; k < 3; k++) begin
        if (kp[k]) begin
          if (space > 0) begin mq.push_back(c[k]); space--; end
          else if (m_drop < 65535) m_drop++;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_st.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL status_queue: got empty expected entry at %0t", $time);
      end else begin
        st_t s;
        s = exp_st.pop_front();
        chk("count", a64'(count), a64'(s.cnt));
        chk("drop_cnt", a64'(drop_cnt), a64'(s.drop));
        chk("req_valid", a64'(req_valid), a64'(s.vld));
      end
      if (req_valid && ready) begin
        if (exp_issue.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue: got 0x%0h expected none at %0t", req_addr, $time);
        end else chk("issue_addr", req_addr, exp_issue.pop_front());
      end
    end
  end

  initial begin
    a64 ln;
    rst = 0; v1 = 0; v2 = 0; v3 = 0; a1 = 0; a2 = 0; a3 = 0; flush = 0; ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", a64'(count), 0);
    chk("rst_valid", a64'(req_valid), 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_drop", a64'(drop_cnt), 0);
    rst = 1;

    // single entry
    cyc(1, 64'h1040, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
    // same-cycle duplicate
    cyc(1, 64'h2000, 1, 64'h2010, 1, 64'h2080, 0, 0);
    idle(2, 0);
    idle(4, 1);
    // overflow
    for (int i = 0; i < 5; i++)
      cyc(1, 64'h10000 + i*192, 1, 64'h10040 + i*192, 1, 64'h10080 + i*192, 0, 0);
    // wrap with simultaneous enqueue/dequeue
    for (int i = 0; i < 20; i++) cyc(1, 64'h20000 + i*64, 0, 0, 0, 0, 0, 1);
    idle(10, 1);
    // flush with count 5 during a two-candidate enqueue
    cyc(1, 64'h30040, 1, 64'h30080, 1, 64'h300c0, 0, 0);
    cyc(1, 64'h30100, 1, 64'h30140, 0, 0, 0, 0);
    cyc(1, 64'h30180, 1, 64'h301c0, 0, 0, 1, 0);
    idle(2, 1);
    // recently issued line presented again
    cyc(1, 64'h3000, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
    cyc(1, 64'h3000, 0, 0, 0, 0, 0, 1);
    idle(3, 1);

    // random traffic over a small line pool to provoke duplicates
    for (int i = 0; i < 2000; i++) begin
      a64 r[3];
      for (int k = 0; k < 3; k++) begin
        ln = a64'($urandom_range(0, 23));
        r[k] = 64'h0000_1234_0000_0000 | (ln << 6) | a64'($urandom_range(0, 63));
      end
      cyc($urandom_range(0, 1), r[0], $urandom_range(0, 1), r[1], $urandom_range(0, 1), r[2],
          ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7));
    end
    idle(12, 1);
    @(negedge clk); #1;
    chk("issue_drained", a64'(exp_issue.size()), 0);

    // reset in the middle of traffic
    cyc(1, 64'h5000, 1, 64'h5040, 1, 64'h5080, 0, 0);
    cyc(1, 64'h50c0, 0, 0, 0, 0, 0, 0);
    #2;
    mon_en = 0;
    rst = 0;
    #1;
    chk("midrst_count", a64'(count), 0);
    chk("midrst_valid", a64'(req_valid), 0);
    chk("midrst_addr", req_addr, 0);
    chk("midrst_drop", a64'(drop_cnt), 0);
    exp_st.delete(); exp_issue.delete(); mq.delete(); filt.delete(); m_drop = 0;
    v1 = 0; v2 = 0; v3 = 0; flush = 0; ready = 0;
    @(posedge clk); #1;
    rst = 1;
    cyc(1, 64'h6040, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
    @(negedge clk); #1;
    chk("final_drained", a64'(exp_issue.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pref_queue.md
# pref_queue

Prefetch request queue sitting directly downstream of the IP-stride prefetcher. Each cycle it accepts up to three candidate prefetch addresses, filters duplicates at cache-line granularity, buffers survivors in a circular FIFO, and issues them one per cycle to the cache/memory request port over a valid/ready handshake. Candidates that do not fit are dropped and counted. The prefetcher is never back-pressured.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 4.
- ADDR_SIZE, 64: address width.
- LOG2_BLOCK_SIZE, 6: cache-line offset bits ignored for duplicate compares.
- FILTER_ENTRIES, 16: recent-issue filter size; used only with the filter macro.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous assert, active-low, deasserted synchronously to clk.
- pref_addr1_i / pref_addr2_i / pref_addr3_i  in  ADDR_SIZE  candidate addresses, stride ×1/×2/×3.
- pref_valid1_i / pref_valid2_i / pref_valid3_i  in  1  candidate valid.
- flush_i  in  1  discards all queued entries.
- req_addr_o  out  ADDR_SIZE  head address, block-aligned (low LOG2_BLOCK_SIZE bits zero).
- req_valid_o  out  1  head valid.
- req_ready_i  in  1  consumer accepts the head.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- drop_cnt_o  out  16  saturating count of candidates dropped for lack of space.

## Operation
- Line address (cla) = addr >> LOG2_BLOCK_SIZE. Every compare uses cla. Stored and issued addresses are cla << LOG2_BLOCK_SIZE.
- Candidate priority: 1 > 2 > 3.
- A candidate is a duplicate, and is silently discarded (not counted as a drop), if either holds:
  - its cla equals a higher-priority valid candidate in the same cycle;
  - its cla equals any occupied FIFO entry, including a head being dequeued this cycle.
- Space = DEPTH − count at the start of the cycle. A dequeue in the same cycle does not free a slot for that cycle's enqueue.
- Surviving candidates are written in priority order into consecutive slots from the tail. Candidates beyond the available space are dropped, lowest priority first. Each drop increments drop_cnt_o, which saturates at 16'hFFFF.
- A dequeue happens when req_valid_o && req_ready_i. The head pointer advances by one.
- Head and tail pointers wrap modulo DEPTH. Full/empty is determined from count, not from pointer equality.
- count_next = count + enqueued − dequeued.
- flush_i: the next state is empty and pointers return to 0. Flush overrides enqueue in the same cycle; those candidates are neither stored nor counted as drops. A handshake completing in the flush cycle still counts as issued. drop_cnt_o is not cleared by flush.
- req_valid_o and req_addr_o hold stable until the handshake completes.

## Timing
- Reset values: req_valid_o = 0, req_addr_o = 0, count_o = 0, drop_cnt_o = 0, all entries invalid, pointers at 0.
- Enqueue latency: a candidate presented in cycle N appears at the head no earlier than N+1. There is no bypass.
- Throughput: three enqueues and one dequeue per cycle.
- req_valid_o, req_addr_o and count_o are driven directly from flops, with no combinational path from any input.
- Reset asserted mid-operation clears all state immediately. No request is in flight after reset.

## Configuration
- PREF_QUEUE_RECENT_FILTER_EN defined:
  - adds a FILTER_ENTRIES-deep round-robin buffer of recently issued cla values, written on each completed handshake;
  - candidates matching any valid filter entry are discarded as duplicates;
  - the filter is cleared by reset, not by flush_i.
- Undefined: no filter logic. Duplicate checks cover only same-cycle candidates and FIFO contents.

## Structure
- The shared package pref_pkg holds ADDR_SIZE, LOG2_BLOCK_SIZE, addr_t, cla_t and a to_cla function. The prefetcher uses the same package.
- One sub-module, pref_cla_match: a parameterised N-entry valid/cla CAM returning a hit bit. It is instantiated for the FIFO compare and for the recent filter.

## Test plan
- Single entry: after reset, candidate 1 = 0x1040 valid, ready = 1 → req_valid_o = 1 with req_addr_o = 0x1040 in the next cycle; count_o goes 0 → 1 → 0.
- Same-cycle duplicate: candidates 0x2000, 0x2010, 0x2080 → only 0x2000 and 0x2080 are queued, in that order; drop_cnt_o = 0.
- Overflow: with ready = 0, apply three distinct candidates per cycle on a DEPTH = 8 queue → after cycle 3, count = 8 and drop_cnt_o = 1 (the third cycle's candidate 3 is dropped). Further cycles add 3 drops each.
- Wrap with simultaneous enqueue/dequeue: with a full queue and ready = 1, apply one new candidate per cycle for 20 cycles → the issue order equals the insertion order and count stays at 7 or 8.
- Flush: flush_i during an enqueue of 2 candidates with a queue count of 5 → count = 0 and req_valid_o = 0 in the next cycle; drop_cnt_o is unchanged.
- Filter (macro defined): issue 0x3000, then present 0x3000 again 3 cycles later → not enqueued. With the macro undefined, the same stimulus issues 0x3000 twice.
